// File: rtl/stack_ctrl.sv
// Push/pop sequencer for the stack-pointer + stack-memory pair; owns occupancy and error status.
// Optional peek (i_peek, PEEK_DONE state) is compiled in when STACK_CTRL_PEEK_EN is defined.
module stack_ctrl #(
  parameter int DEPTH   = 256,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_push,
  input  logic               i_pop,
`ifdef STACK_CTRL_PEEK_EN
  input  logic               i_peek,
`endif
  input  logic [0:15]        i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [0:15]        o_data,
  inout  wire  [0:15]        bus,
  output logic [0:2]         o_sp_ctrl,
  output logic               o_mem_w,
  output logic               o_mem_s,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_err,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH_INC  = 3'd1,
    PUSH_WR   = 3'd2,
    POP_RD    = 3'd3,
    POP_DEC   = 3'd4
`ifdef STACK_CTRL_PEEK_EN
    ,PEEK_DONE = 3'd5
`endif
  } state_t;

  localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(DEPTH);

  state_t      state;
  logic [0:15] data_q;
  logic        req_err;
`ifdef STACK_CTRL_PEEK_EN
  logic        peek_q;
`endif

  // Handshake: a request is taken on the rising edge where o_ready (IDLE) is high;
  // requests raised outside IDLE are ignored, not queued. o_valid is a one-cycle pulse.
  always_comb begin
    req_err = (i_pop && o_empty) || (i_push && o_full);
`ifdef STACK_CTRL_PEEK_EN
    req_err = req_err || (i_peek && o_empty);
`endif
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      data_q  <= 16'h0000;
      o_data  <= 16'h0000;
      o_depth <= '0;
      o_err   <= 1'b0;
`ifdef STACK_CTRL_PEEK_EN
      peek_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_pop && !o_empty) begin
            state <= POP_RD;
`ifdef STACK_CTRL_PEEK_EN
            peek_q <= 1'b0;
`endif
          end else if (i_push && !o_full) begin
            state  <= PUSH_INC;
            data_q <= i_data;
`ifdef STACK_CTRL_PEEK_EN
          end else if (i_peek && !o_empty) begin
            state  <= POP_RD;
            peek_q <= 1'b1;
`endif
          end else if (req_err) begin
            o_err <= 1'b1;
          end
        end
        PUSH_INC: state <= PUSH_WR;
        PUSH_WR: begin
          o_depth <= o_depth + DEPTH_W'(1);
          state   <= IDLE;
        end
        POP_RD: begin
          o_data <= bus;
`ifdef STACK_CTRL_PEEK_EN
          state  <= peek_q ? PEEK_DONE : POP_DEC;
`else
          state  <= POP_DEC;
`endif
        end
        POP_DEC: begin
          o_depth <= o_depth - DEPTH_W'(1);
          state   <= IDLE;
        end
`ifdef STACK_CTRL_PEEK_EN
        PEEK_DONE: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below decodes the state/depth registers only: no input-to-output paths.
  assign o_ready     = (state == IDLE);
`ifdef STACK_CTRL_PEEK_EN
  assign o_valid     = (state == POP_DEC) || (state == PEEK_DONE);
`else
  assign o_valid     = (state == POP_DEC);
`endif
  assign o_sp_ctrl   = (state == PUSH_INC) ? 3'b001 :
                       (state == POP_DEC)  ? 3'b010 : 3'b000;
  assign o_mem_w     = (state == PUSH_WR);
  assign o_mem_s     = (state != POP_RD);
  assign bus         = (state == PUSH_WR) ? data_q : {16{1'bz}};
  assign o_full      = (o_depth == FULL_CNT);
  assign o_empty     = (o_depth == '0);
  assign o_dbg_state = state;

endmodule
